// File: rtl/fiber_dram_responder.sv
// DRAM-side responder for the fiber cache: word-addressed backing store that
// absorbs writebacks and returns line-fill words after a programmable latency.
module fiber_dram_responder #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 64,
   parameter int MEM_AW     = 8,
   parameter int LATENCY    = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_fill_ready,
   output logic [DATA_WIDTH-1:0] o_fill_data,
   output logic                  o_fill_valid,
   input  logic [DATA_WIDTH-1:0] i_wb_data,
   input  logic                  i_wb_valid,
   output logic                  o_wb_ready,
   output logic                  o_busy,
   output logic [CNT_WIDTH-1:0]  o_rd_cnt,
   output logic [CNT_WIDTH-1:0]  o_wr_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_RESP = 2'd2
   } state_t;

   localparam logic [7:0] LP_LAT_INIT = 8'(LATENCY - 1);

   logic [DATA_WIDTH-1:0] r_mem [0:(2**MEM_AW)-1];
   state_t                r_state;
   logic [MEM_AW-1:0]     r_idx;
   logic [7:0]            r_lat;
   logic [DATA_WIDTH-1:0] r_fill_data;
   logic                  r_fill_valid;
   logic [CNT_WIDTH-1:0]  r_rd_cnt;
   logic [CNT_WIDTH-1:0]  r_wr_cnt;

   logic [MEM_AW-1:0]     w_idx;
   logic                  w_wb_ready;
   logic                  w_wb_fire;
   logic                  w_unused_addr;

   // Upper address bits alias onto the same word.
   assign w_idx         = i_addr[MEM_AW-1:0];
   assign w_unused_addr = ^i_addr[ADDR_WIDTH-1:MEM_AW];
   assign w_wb_ready    = (r_state == IDLE) && !i_reset;
   assign w_wb_fire     = i_wb_valid && w_wb_ready;

   // Backing store has no reset so its contents survive a reset pulse.
   always_ff @(posedge i_clk) begin
      if (w_wb_fire) begin
         r_mem[w_idx] <= i_wb_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_idx        <= {MEM_AW{1'b0}};
         r_lat        <= 8'd0;
         r_fill_data  <= {DATA_WIDTH{1'b0}};
         r_fill_valid <= 1'b0;
         r_rd_cnt     <= {CNT_WIDTH{1'b0}};
         r_wr_cnt     <= {CNT_WIDTH{1'b0}};
      end else begin
         case (r_state)
            IDLE: begin
               if (w_wb_fire) begin
                  r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
               end else if (i_fill_ready) begin
                  r_idx   <= w_idx;
                  r_lat   <= LP_LAT_INIT;
                  r_state <= RD_WAIT;
               end else begin
                  r_state <= IDLE;
               end
            end
            RD_WAIT: begin
               // Data is read at response time so prior writes are always seen.
               if (r_lat == 8'd0) begin
                  r_fill_data  <= r_mem[r_idx];
                  r_fill_valid <= 1'b1;
                  r_state      <= RD_RESP;
               end else begin
                  r_lat <= r_lat - 8'd1;
               end
            end
            RD_RESP: begin
               if (i_fill_ready) begin
                  r_fill_valid <= 1'b0;
                  r_rd_cnt     <= r_rd_cnt + CNT_WIDTH'(1);
                  r_state      <= IDLE;
               end else begin
                  r_state <= RD_RESP;
               end
            end
            default: begin
               r_fill_valid <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign o_fill_data  = r_fill_data;
   assign o_fill_valid = r_fill_valid;
   assign o_wb_ready   = w_wb_ready;
   assign o_busy       = (r_state != IDLE);
   assign o_rd_cnt     = r_rd_cnt;
   assign o_wr_cnt     = r_wr_cnt;

endmodule

// File: tb/tb_fiber_dram_responder.sv
// Self-checking bench for fiber_dram_responder: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a fill/writeback model.
module tb_fiber_dram_responder;

   localparam int DW  = 16;
   localparam int AW  = 64;
   localparam int MAW = 8;
   localparam int LAT = 4;
   localparam int CW  = 8;

   logic          i_clk;
   logic          i_reset;
   logic [AW-1:0] i_addr;
   logic          i_fill_ready;
   logic [DW-1:0] o_fill_data;
   logic          o_fill_valid;
   logic [DW-1:0] i_wb_data;
   logic          i_wb_valid;
   logic          o_wb_ready;
   logic          o_busy;
   logic [CW-1:0] o_rd_cnt;
   logic [CW-1:0] o_wr_cnt;

   fiber_dram_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .LATENCY(LAT), .CNT_WIDTH(CW)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_addr(i_addr), .i_fill_ready(i_fill_ready),
      .o_fill_data(o_fill_data), .o_fill_valid(o_fill_valid), .i_wb_data(i_wb_data),
      .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready), .o_busy(o_busy),
      .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Transaction-level model: one outstanding fill with an edge countdown.
   logic [DW-1:0] m_mem [256];
   bit            m_wr  [256];
   bit            m_pend;
   bit            m_valid;
   int            m_wait;
   int            m_idx;
   logic [DW-1:0] m_data;
   bit            m_known;
   int            m_rd;
   int            m_wrc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_edge();
      int idx;
      idx = int'(i_addr[MAW-1:0]);
      if (i_reset) begin
         m_pend = 1'b0; m_valid = 1'b0; m_data = '0; m_known = 1'b1;
         m_rd = 0; m_wrc = 0; m_wait = 0;
      end else if (!m_pend) begin
         if (i_wb_valid) begin
            m_mem[idx] = i_wb_data; m_wr[idx] = 1'b1;
            m_wrc = (m_wrc + 1) % 256;
         end else if (i_fill_ready) begin
            m_pend = 1'b1; m_idx = idx; m_wait = LAT;
         end
      end else if (!m_valid) begin
         m_wait--;
         if (m_wait == 0) begin
            m_valid = 1'b1; m_data = m_mem[m_idx]; m_known = m_wr[m_idx];
         end
      end else if (i_fill_ready) begin
         m_valid = 1'b0; m_pend = 1'b0;
         m_rd = (m_rd + 1) % 256;
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("fill_valid", 64'(o_fill_valid), 64'(m_valid));
         chk("busy",       64'(o_busy),       64'(m_pend));
         chk("wb_ready",   64'(o_wb_ready),   64'(!m_pend && !i_reset));
         chk("rd_cnt",     64'(o_rd_cnt),     64'(m_rd));
         chk("wr_cnt",     64'(o_wr_cnt),     64'(m_wrc));
         if (m_known) chk("fill_data", 64'(o_fill_data), 64'(m_data));
      end
   end

   task automatic step();
      @(posedge i_clk);
      model_edge();
      chk_en = 1'b1;
      @(negedge i_clk);
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!o_fill_valid && n < 50);
   endtask

   task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
      i_addr = a; i_wb_data = d; i_wb_valid = 1'b1;
      step();
      i_wb_valid = 1'b0;
   endtask

   int n;
   logic [DW-1:0] held;

   initial begin
      for (int i = 0; i < 256; i++) begin m_wr[i] = 1'b0; m_mem[i] = '0; end
      m_pend = 0; m_valid = 0; m_data = '0; m_known = 0; m_rd = 0; m_wrc = 0; m_wait = 0; m_idx = 0;
      i_reset = 1'b1; i_addr = '0; i_fill_ready = 1'b0; i_wb_data = '0; i_wb_valid = 1'b0;

      // Reset held for two cycles
      step();
      chk("wb_ready_in_reset", 64'(o_wb_ready), 64'd0);
      step();
      chk("wb_ready_in_reset2", 64'(o_wb_ready), 64'd0);
      i_reset = 1'b0;
      #1;
      chk("wb_ready_after_reset", 64'(o_wb_ready), 64'd1);
      chk("valid_after_reset", 64'(o_fill_valid), 64'd0);
      chk("busy_after_reset", 64'(o_busy), 64'd0);
      chk("rd_after_reset", 64'(o_rd_cnt), 64'd0);
      chk("wr_after_reset", 64'(o_wr_cnt), 64'd0);

      // Write then read with ready held high
      do_wb(64'h0000_0000_FFFF_FFFF, 16'hFFFF);
      chk("wr_cnt_1", 64'(o_wr_cnt), 64'd1);
      i_fill_ready = 1'b1;
      step();
      chk("busy_after_capture", 64'(o_busy), 64'd1);
      wait_valid(n);
      chk("latency_edges", 64'(n), 64'd4);
      chk("fill_data_ffff", 64'(o_fill_data), 64'h0000_0000_0000_FFFF);
      step();
      i_fill_ready = 1'b0;
      chk("valid_drop", 64'(o_fill_valid), 64'd0);
      chk("rd_cnt_1", 64'(o_rd_cnt), 64'd1);
      chk("busy_idle", 64'(o_busy), 64'd0);

      // Writeback wins over a simultaneous fill request
      i_addr = 64'h10; i_wb_data = 16'h1234; i_wb_valid = 1'b1; i_fill_ready = 1'b1;
      step();
      i_wb_valid = 1'b0;
      chk("prio_wr_cnt", 64'(o_wr_cnt), 64'd2);
      chk("prio_not_busy", 64'(o_busy), 64'd0);
      step();
      chk("prio_capture", 64'(o_busy), 64'd1);
      wait_valid(n);
      chk("prio_latency", 64'(n), 64'd4);
      chk("prio_data", 64'(o_fill_data), 64'h1234);
      step();
      i_fill_ready = 1'b0;

      // Backpressure holds the response stable
      i_fill_ready = 1'b1;
      step();
      i_fill_ready = 1'b0;
      i_addr = 64'h55;
      wait_valid(n);
      chk("bp_latency", 64'(n), 64'd4);
      held = o_fill_data;
      chk("bp_data", 64'(held), 64'h1234);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("bp_valid_held", 64'(o_fill_valid), 64'd1);
         chk("bp_data_held", 64'(o_fill_data), 64'h1234);
      end
      i_fill_ready = 1'b1;
      step();
      i_fill_ready = 1'b0;
      chk("bp_valid_drop", 64'(o_fill_valid), 64'd0);
      chk("bp_rd_cnt", 64'(o_rd_cnt), 64'd3);

      // Reset while waiting abandons the fill
      i_addr = 64'h10; i_fill_ready = 1'b1;
      step();
      i_fill_ready = 1'b0;
      step();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      chk("rst_wait_valid", 64'(o_fill_valid), 64'd0);
      chk("rst_wait_busy", 64'(o_busy), 64'd0);
      chk("rst_wait_rd", 64'(o_rd_cnt), 64'd0);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rst_no_valid", 64'(o_fill_valid), 64'd0);
      end
      i_fill_ready = 1'b1;
      step();
      wait_valid(n);
      chk("post_rst_latency", 64'(n), 64'd4);
      chk("post_rst_data", 64'(o_fill_data), 64'h1234);
      step();
      i_fill_ready = 1'b0;
      chk("post_rst_rd", 64'(o_rd_cnt), 64'd1);

      // Aliasing: 0x1FF and 0x0FF share a word
      do_wb(64'h1FF, 16'hBEEF);
      i_addr = 64'h0FF; i_fill_ready = 1'b1;
      step();
      wait_valid(n);
      chk("alias_data", 64'(o_fill_data), 64'hBEEF);
      step();
      i_fill_ready = 1'b0;

      // 256 back-to-back writebacks wrap the counter
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      i_wb_valid = 1'b1;
      for (int k = 0; k < 256; k++) begin
         i_addr = {32'($urandom), 32'($urandom)};
         i_wb_data = 16'($urandom);
         step();
      end
      i_wb_valid = 1'b0;
      chk("wr_wrap", 64'(o_wr_cnt), 64'd0);

      // Randomized traffic
      for (int k = 0; k < 4000; k++) begin
         i_reset      = ($urandom_range(0, 99) == 0);
         i_wb_valid   = ($urandom_range(0, 2) == 0);
         i_fill_ready = ($urandom_range(0, 1) == 1);
         i_addr       = {32'($urandom), 24'($urandom), 8'($urandom_range(0, 15))};
         i_wb_data    = 16'($urandom);
         step();
      end
      i_reset = 1'b0; i_wb_valid = 1'b0; i_fill_ready = 1'b0;
      step();
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
